// File: rtl/pipe_elastic_reg.sv
// Elastic inter-stage pipeline register: a DEPTH-entry FIFO with valid/ready on
// both sides, a global flush that empties it and a global freeze that holds it.
module pipe_elastic_reg #(
   parameter int unsigned DATA_WD = 64,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     freeze,
   input  logic                     in_valid,
   input  logic [DATA_WD-1:0]       in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_WD-1:0]       out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_WD = $clog2(DEPTH);
   localparam int unsigned CNT_WD = $clog2(DEPTH) + 1;

   logic [DATA_WD-1:0] mem_q [DEPTH];
   logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WD-1:0]  cnt_q, cnt_d;

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               mem_we;

   // Handshake outputs; in_ready never looks at out_ready, so no ready chain forms.
   always_comb begin
      full      = (cnt_q == CNT_WD'(DEPTH));
      empty     = (cnt_q == '0);
      in_ready  = ~full & ~freeze;
      out_valid = ~empty & ~freeze;
      out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
      count     = cnt_q;
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Next state: flush drops everything, including a same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         mem_we = push;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_WD'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WD'(1);
         end
         cnt_d = cnt_q + CNT_WD'(push) - CNT_WD'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: DEPTH=2 and DEPTH=4 instances share stimulus and are
// each checked against a queue-based reference model, plus directed spot checks.
module tb_pipe_elastic_reg;

   logic        clk = 1'b0;
   logic        rst, flush, freeze, in_valid, out_ready;
   logic [63:0] in_data;

   logic        ir2, ov2, ir4, ov4;
   logic [63:0] od2, od4;
   logic [1:0]  c2;
   logic [2:0]  c4;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [63:0] q2[$];
   logic [63:0] q4[$];

   always #5 clk = ~clk;

   pipe_elastic_reg #(.DATA_WD(64), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir2),
      .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .count(c2));

   pipe_elastic_reg #(.DATA_WD(64), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
      .out_valid(ov4), .out_data(od4), .out_ready(out_ready), .count(c4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outputs follow from the queue occupancy and the freeze input alone.
   task automatic chk_model(input string tag, input int depth, input int sz,
                            input logic [63:0] head, input logic ir, input logic ov,
                            input logic [63:0] od, input logic [63:0] cnt);
      logic e_ir, e_ov;
      e_ir = (sz < depth) && !freeze;
      e_ov = (sz > 0) && !freeze;
      chk({tag, ".in_ready"},  64'(ir), 64'(e_ir));
      chk({tag, ".out_valid"}, 64'(ov), 64'(e_ov));
      chk({tag, ".out_data"},  od, e_ov ? head : 64'h0);
      chk({tag, ".count"},     cnt, 64'(sz));
   endtask

   // One clock: check before the edge, then advance the models with that edge.
   task automatic step();
      bit p2, o2, p4, o4;
      logic [63:0] h2, h4;
      @(negedge clk);
      h2 = (q2.size() > 0) ? q2[0] : 64'h0;
      h4 = (q4.size() > 0) ? q4[0] : 64'h0;
      if (chk_en) begin
         chk_model("d2", 2, q2.size(), h2, ir2, ov2, od2, 64'(c2));
         chk_model("d4", 4, q4.size(), h4, ir4, ov4, od4, 64'(c4));
      end
      p2 = in_valid && (q2.size() < 2) && !freeze;
      o2 = out_ready && (q2.size() > 0) && !freeze;
      p4 = in_valid && (q4.size() < 4) && !freeze;
      o4 = out_ready && (q4.size() > 0) && !freeze;
      @(posedge clk);
      #1;
      if (rst || flush) begin
         q2.delete();
         q4.delete();
      end else begin
         if (o2) void'(q2.pop_front());
         if (p2) q2.push_back(in_data);
         if (o4) void'(q4.pop_front());
         if (p4) q4.push_back(in_data);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; freeze = 1'b0;
      in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b0;

      // Reset with a live upstream
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst.count",    64'(c2), 64'd0);
      chk("rst.outvalid", 64'(ov2), 64'd0);
      chk("rst.outdata",  od2, 64'd0);
      chk("rst.inready",  64'(ir2), 64'd1);
      step();

      // Single push, then pop
      in_valid = 1'b1; in_data = 64'h1234; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      #1;
      chk("single.outvalid", 64'(ov2), 64'd1);
      chk("single.outdata",  od2, 64'h1234);
      chk("single.count",    64'(c2), 64'd1);
      out_ready = 1'b1;
      step();
      chk("single.popvalid", 64'(ov2), 64'd0);
      chk("single.popdata",  od2, 64'd0);

      // Fill DEPTH=2 and push against backpressure
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'h11; step();
      in_data = 64'h22; step();
      chk("full.count",   64'(c2), 64'd2);
      chk("full.inready", 64'(ir2), 64'd0);
      in_data = 64'h33; step();
      chk("full.count33", 64'(c2), 64'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("full.popdata",  od2, 64'h22);
      chk("full.inready1", 64'(ir2), 64'd1);
      repeat (4) step();

      // Streaming through DEPTH=4 with pointer wrap
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_data = 64'(i);
         step();
         chk("stream.data",  od4, 64'(i));
         chk("stream.count", 64'(c4), 64'd1);
      end
      in_valid = 1'b0;
      step();

      // Flush discards contents and the same-cycle push
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'h5; step();
      in_data = 64'h6; step();
      flush = 1'b1; in_data = 64'h7; step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush.count",    64'(c4), 64'd0);
      chk("flush.outvalid", 64'(ov4), 64'd0);
      chk("flush.count2",   64'(c2), 64'd0);
      out_ready = 1'b1;
      repeat (2) step();

      // Freeze holds a single entry and blocks both sides
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h9;
      step();
      freeze = 1'b1; in_valid = 1'b1; in_data = 64'hBB; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("freeze.inready",  64'(ir2), 64'd0);
         chk("freeze.outvalid", 64'(ov2), 64'd0);
         chk("freeze.outdata",  od2, 64'd0);
         chk("freeze.count",    64'(c2), 64'd1);
      end
      freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("freeze.release", od2, 64'h9);
      chk("freeze.release4", od4, 64'h9);
      step();

      // Randomized traffic including occasional flush, freeze and reset
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         in_data   = {32'($urandom), 32'($urandom)};
         freeze    = ($urandom_range(0, 99) < 10);
         flush     = ($urandom_range(0, 99) < 4);
         rst       = ($urandom_range(0, 99) < 2);
         step();
      end
      rst = 1'b0; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_elastic_reg.md
Name: pipe_elastic_reg

Overview:
- Parametrised successor to the fixed-width inter-stage bus register in the CPU pipeline.
- Replaces the single register with a DEPTH-entry elastic buffer. Adds a valid/ready handshake on both sides, a global flush, and a global freeze from the stall controller.
- Instantiated between any two pipeline stages; the stage bus is carried opaquely as in_data/out_data.
- Bubbles are presented as an all-zero bus, which downstream decoders treat as NOP.

Parameters:
- DATA_WD, 64, width of the stage bus in bits.
- DEPTH, 2, number of buffer entries; power of two, >= 2.
- CNT_WD (localparam), $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discard all buffered entries (branch/exception redirect).
- freeze  input  1  global pipeline stall from ctrl; blocks both sides and holds contents.
- in_valid  input  1  upstream presents in_data.
- in_data  input  DATA_WD  upstream stage bus.
- in_ready  output  1  buffer can accept this cycle.
- out_valid  output  1  head entry valid and not frozen.
- out_data  output  DATA_WD  head entry; all zeros when out_valid=0.
- out_ready  input  1  downstream accepts the head this cycle.
- count  output  CNT_WD  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - storage array mem[DEPTH];
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - cnt register.
- Reset (rst=1 at posedge):
  - wr_ptr=rd_ptr=0, cnt=0.
  - Outputs after that edge: count=0, out_valid=0, out_data=0, in_ready=1 (when freeze=0).
  - mem contents need not be cleared.
- Combinational outputs:
  - in_ready = (cnt != DEPTH) & ~freeze. It does not depend on out_ready, so there is no ready pass-through path.
  - out_valid = (cnt != 0) & ~freeze.
  - out_data = out_valid ? mem[rd_ptr] : 0.
  - count = cnt.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - cnt next = cnt + push - pop; simultaneous push and pop leaves cnt unchanged.
- Latency: data pushed at edge t appears on out_data from t+1, when cnt was 0 before the push. No combinational in->out path.
- Full: cnt==DEPTH drives in_ready=0; a pop in that cycle frees a slot for the next cycle only.
- Empty: cnt==0 drives out_valid=0 and out_data=0; a push in that cycle is not visible until the next cycle.
- Priority at posedge: rst > flush > freeze > normal.
- flush=1:
  - wr_ptr=rd_ptr=0, cnt=0.
  - Any push or pop in the same cycle is discarded; the upstream handshake is considered consumed.
  - out_valid=0 in the following cycle.
- freeze=1 (flush=0):
  - in_ready=0 and out_valid=0, so no transfers occur.
  - All state is held; count still shows the real occupancy.
- Flush together with freeze: flush wins and the buffer empties.
- Pointer wrap-around: pointers roll over from DEPTH-1 to 0; ordering is strictly FIFO.
- in_valid without in_ready: no state change; upstream must hold data (not checked).
- in_data is don't-care when in_valid=0.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_data=0xAA -> after release count=0, out_valid=0, out_data=0, in_ready=1.
- Single push, DEPTH=2: push 0x1234 at edge t with out_ready=0 -> from t+1 out_valid=1, out_data=0x1234, count=1. Assert out_ready -> next cycle out_valid=0, out_data=0.
- Full and backpressure, DEPTH=2: push 0x11 then 0x22 with out_ready=0 -> count=2, in_ready=0, a third push (0x33) is not accepted. Pop once -> out_data=0x22, in_ready=1.
- Streaming with wrap, DEPTH=4: 10 consecutive pushes 1..10 with out_ready=1 every cycle -> out sequence 1..10 in order, one per cycle after 1-cycle latency, count stays at 1.
- Flush: buffer holds 0x5,0x6; assert flush together with in_valid=1, in_data=0x7 -> next cycle count=0, out_valid=0; 0x7 never appears at the output.
- Freeze: count=1 with head=0x9; hold freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, out_data=0, count=1 throughout. Release -> out_data=0x9 in the same cycle.
